// File: rtl/pbs_ctrl.sv
// rtl/pbs_ctrl.sv - battle turn-sequencing FSM driving datapath control strobes.
// Optional accuracy roll enabled by defining PBS_ACCU_CHECK_EN.
module pbs_ctrl #(
  parameter int SETTLE    = 2,
  parameter int MAX_TURNS = 15
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       confirm,
  input  logic [1:0] move_sel,
  input  logic [3:0] p_hp,
  input  logic [3:0] ai_hp,
  input  logic [3:0] accu,
  input  logic [3:0] accu_rng,
  output logic       target,
  output logic       stop,
  output logic [1:0] p_move,
  output logic       actr,
  output logic       load_ai_hp,
  output logic       app_pl_dmg,
  output logic       app_ai_dmg,
  output logic       miss,
  output logic [3:0] turn,
  output logic       done,
  output logic [1:0] result
);

  typedef enum logic [3:0] {
    S_IDLE, S_P_SEL, S_P_CALC, S_P_APPLY, S_P_CHECK,
    S_AI_CALC, S_AI_APPLY, S_AI_CHECK, S_DONE
  } state_t;

  localparam logic [3:0] SETTLE_LAST = 4'(SETTLE - 1);
  localparam logic [3:0] TURN_LIMIT  = 4'(MAX_TURNS);

  state_t     state;
  logic [3:0] cnt;
  logic       hit;
  logic [3:0] turn_next;

`ifdef PBS_ACCU_CHECK_EN
  assign hit = (accu >= accu_rng);
`else
  logic unused_accu;
  assign hit         = 1'b1;
  assign unused_accu = ^{accu, accu_rng};
`endif

  assign turn_next = turn + 4'd1;

  // Strobes default low each cycle; the hit decision is registered on APPLY entry
  // while stop=1 keeps the RNG roll stable.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      cnt        <= 4'd0;
      target     <= 1'b0;
      stop       <= 1'b0;
      p_move     <= 2'b00;
      actr       <= 1'b0;
      load_ai_hp <= 1'b0;
      app_pl_dmg <= 1'b0;
      app_ai_dmg <= 1'b0;
      miss       <= 1'b0;
      turn       <= 4'd0;
      done       <= 1'b0;
      result     <= 2'b00;
    end else begin
      load_ai_hp <= 1'b0;
      app_pl_dmg <= 1'b0;
      app_ai_dmg <= 1'b0;
      miss       <= 1'b0;
      case (state)
        S_IDLE: begin
          if (confirm) state <= S_P_SEL;
        end
        S_P_SEL: begin
          if (confirm) begin
            p_move     <= move_sel;
            state      <= S_P_CALC;
            cnt        <= 4'd0;
            load_ai_hp <= 1'b1;
            actr       <= 1'b0;
            target     <= 1'b1;
            stop       <= 1'b1;
          end
        end
        S_P_CALC: begin
          if (cnt == SETTLE_LAST) begin
            state <= S_P_APPLY;
            if (hit) app_ai_dmg <= 1'b1;
            else     miss       <= 1'b1;
          end else begin
            cnt <= cnt + 4'd1;
          end
        end
        S_P_APPLY: state <= S_P_CHECK;
        S_P_CHECK: begin
          if (ai_hp == 4'd0) begin
            result <= 2'b01;
            done   <= 1'b1;
            state  <= S_DONE;
          end else begin
            state  <= S_AI_CALC;
            cnt    <= 4'd0;
            actr   <= 1'b1;
            target <= 1'b0;
          end
        end
        S_AI_CALC: begin
          if (cnt == SETTLE_LAST) begin
            state <= S_AI_APPLY;
            if (hit) app_pl_dmg <= 1'b1;
            else     miss       <= 1'b1;
          end else begin
            cnt <= cnt + 4'd1;
          end
        end
        S_AI_APPLY: state <= S_AI_CHECK;
        S_AI_CHECK: begin
          if (p_hp == 4'd0) begin
            result <= 2'b10;
            done   <= 1'b1;
            state  <= S_DONE;
          end else begin
            turn <= turn_next;
            if (turn_next == TURN_LIMIT) begin
              result <= 2'b11;
              done   <= 1'b1;
              state  <= S_DONE;
            end else begin
              stop  <= 1'b0;
              state <= S_P_SEL;
            end
          end
        end
        S_DONE: state <= S_DONE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pbs_ctrl.sv
// tb/tb_pbs_ctrl.sv - scoreboard bench for pbs_ctrl.
// Stimulus pushes expected strobe/done events; a negedge monitor pops and compares.
module tb_pbs_ctrl;
  localparam int S = 2;

  localparam logic [2:0] EV_LOAD  = 3'd0;
  localparam logic [2:0] EV_AIDMG = 3'd1;
  localparam logic [2:0] EV_PLDMG = 3'd2;
  localparam logic [2:0] EV_MISS  = 3'd3;
  localparam logic [2:0] EV_DONE  = 3'd4;

  typedef struct {
    logic [2:0] kind;
    int         cyc;
    logic [5:0] data;
  } ev_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       confirm = 1'b0;
  logic [1:0] move_sel = 2'b00;
  logic [3:0] p_hp = 4'd15;
  logic [3:0] ai_hp = 4'd15;
  logic [3:0] accu = 4'd0;
  logic [3:0] accu_rng = 4'd0;
  logic       target, stop, actr, load_ai_hp, app_pl_dmg, app_ai_dmg, miss, done;
  logic [1:0] p_move, result;
  logic [3:0] turn;

  int  checks = 0;
  int  failures = 0;
  int  cyc = 0;
  logic prev_done = 1'b0;
  ev_t q[$];

  pbs_ctrl #(.SETTLE(S), .MAX_TURNS(15)) dut (
    .clk(clk), .rst(rst), .confirm(confirm), .move_sel(move_sel),
    .p_hp(p_hp), .ai_hp(ai_hp), .accu(accu), .accu_rng(accu_rng),
    .target(target), .stop(stop), .p_move(p_move), .actr(actr),
    .load_ai_hp(load_ai_hp), .app_pl_dmg(app_pl_dmg), .app_ai_dmg(app_ai_dmg),
    .miss(miss), .turn(turn), .done(done), .result(result)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic void push(input logic [2:0] kind, input int c, input logic [5:0] d);
    ev_t e;
    e.kind = kind;
    e.cyc  = c;
    e.data = d;
    q.push_back(e);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic observe(input logic [2:0] kind, input logic [5:0] d);
    ev_t e;
    checks++;
    if (q.size() == 0) begin
      failures++;
      $display("FAIL sb_unexpected got kind=%0d cyc=%0d data=%0h required=no event", kind, cyc, d);
    end else begin
      e = q.pop_front();
      if (e.kind !== kind || e.cyc != cyc || e.data !== d) begin
        failures++;
        $display("FAIL sb_event got kind=%0d cyc=%0d data=%0h required kind=%0d cyc=%0d data=%0h",
                 kind, cyc, d, e.kind, e.cyc, e.data);
      end
    end
  endtask

  always @(negedge clk) begin
    if (rst) begin
      prev_done = 1'b0;
    end else begin
      if (load_ai_hp) observe(EV_LOAD, {4'b0000, p_move});
      if (app_ai_dmg) observe(EV_AIDMG, 6'd0);
      if (app_pl_dmg) observe(EV_PLDMG, 6'd0);
      if (miss)       observe(EV_MISS, 6'd0);
      if (done && !prev_done) observe(EV_DONE, {turn, result});
      prev_done = done;
    end
  end

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  // Called at a negedge; leaves confirm high across exactly one posedge.
  task automatic pulse_confirm();
    confirm = 1'b1;
    @(negedge clk);
    confirm = 1'b0;
  endtask

  // outcome: 0 continue, 1 player win, 2 AI win, 3 draw. Called at a negedge in P_SEL.
  task automatic do_turn(input logic [1:0] mv, input int outcome,
                         input logic [3:0] turns_after, input logic hit_exp);
    int k;
    int endc;
    logic [1:0] res;
    res = 2'(outcome);
    move_sel = mv;
    k = cyc + 1;
    push(EV_LOAD, k, {4'b0000, mv});
    push(hit_exp ? EV_AIDMG : EV_MISS, k + S, 6'd0);
    if (outcome == 1) begin
      push(EV_DONE, k + S + 2, {turns_after, res});
      endc = k + S + 2;
    end else begin
      push(hit_exp ? EV_PLDMG : EV_MISS, k + 2*S + 2, 6'd0);
      if (outcome >= 2) push(EV_DONE, k + 2*S + 4, {turns_after, res});
      endc = k + 2*S + 4;
    end
    pulse_confirm();
    while (cyc < endc) @(negedge clk);
  endtask

  initial begin
    int k;
    // Reset with confirm held high: reset must win.
    confirm = 1'b1;
    repeat (2) @(negedge clk);
    confirm = 1'b0;
    check("rst_strobes", {target, stop, actr, load_ai_hp, app_pl_dmg, app_ai_dmg, miss, done}, 0);
    check("rst_p_move", p_move, 0);
    check("rst_turn", turn, 0);
    check("rst_result", result, 0);
    rst = 1'b0;
    @(negedge clk);
    check("idle_stop", stop, 0);

    // Player KO on first attack; app_ai_dmg exactly S cycles after load_ai_hp.
    ai_hp = 4'd0;
    p_hp  = 4'd15;
    pulse_confirm();
    check("psel_stop", stop, 0);
    do_turn(2'b10, 1, 4'd0, 1'b1);
    check("pko_result", result, 2'b01);
    check("pko_done", done, 1);
    check("pko_p_move", p_move, 2'b10);
    pulse_confirm();
    repeat (12) @(negedge clk);
    check("done_sticky", {done, result, turn}, {1'b1, 2'b01, 4'd0});

    // AI KO: turn stays 0.
    do_reset();
    ai_hp = 4'd5;
    p_hp  = 4'd0;
    pulse_confirm();
    do_turn(2'b01, 2, 4'd0, 1'b1);
    check("aiko_result", result, 2'b10);
    check("aiko_turn", turn, 0);

    // Draw after 15 full turns.
    do_reset();
    ai_hp = 4'd15;
    p_hp  = 4'd15;
    pulse_confirm();
    for (int i = 0; i < 14; i++) do_turn(2'(i), 0, 4'(i + 1), 1'b1);
    check("draw_turn14", turn, 14);
    do_turn(2'b11, 3, 4'd15, 1'b1);
    check("draw_turn", turn, 15);
    check("draw_result", {done, result}, {1'b1, 2'b11});

`ifdef PBS_ACCU_CHECK_EN
    // Miss then boundary hit (accu == accu_rng).
    do_reset();
    pulse_confirm();
    accu = 4'd3;
    accu_rng = 4'd9;
    do_turn(2'b00, 0, 4'd1, 1'b0);
    accu = 4'd9;
    do_turn(2'b01, 0, 4'd2, 1'b1);
    check("miss_turn", turn, 2);
    accu = 4'd0;
    accu_rng = 4'd0;
`endif

    // Mid-turn reset during AI_CALC.
    do_reset();
    pulse_confirm();
    move_sel = 2'b11;
    k = cyc + 1;
    push(EV_LOAD, k, 6'b000011);
    push(EV_AIDMG, k + S, 6'd0);
    pulse_confirm();
    while (cyc < k + S + 2) @(negedge clk);
    check("aicalc_actr_target", {actr, target, stop}, {1'b1, 1'b0, 1'b1});
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("midrst_outs", {actr, stop, target, done, load_ai_hp, app_pl_dmg, app_ai_dmg, miss}, 0);
    check("midrst_turn", turn, 0);
    repeat (10) @(negedge clk);

    check("sb_drain", q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got=running required=finished");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1, "timeout");
  end

endmodule
